cache_miss_sequencer: RTL

//   Upstream stage of the DMA block. Accepts one cache-miss request at a time from the cache

---
 rtl/cache_miss_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cache_miss_sequencer.sv
// Cache-miss sequencer: accepts one miss at a time, optionally writes back the dirty victim,
// then refills the line through the DMA request/done handshakes.
module cache_miss_sequencer #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned LINE_OFFSET     = 5,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic                       miss_dirty,
  input  logic [ADDR_WIDTH-1:0]      miss_victim_addr,
  input  logic [ADDR_WIDTH-1:0]      miss_fill_addr,
  input  logic [BURST_LEN_WIDTH-1:0] miss_burst_len,
  output logic                       miss_done,
  output logic                       miss_error,
  output logic                       dma_write_back_happen,
  input  logic                       dma_write_back_done,
  output logic [ADDR_WIDTH-1:0]      dma_write_back_addr,
  output logic [BURST_LEN_WIDTH-1:0] dma_write_back_burst_len,
  output logic                       dma_page_fault_happen,
  input  logic                       dma_page_fault_done,
  output logic [ADDR_WIDTH-1:0]      dma_page_fault_addr,
  output logic [BURST_LEN_WIDTH-1:0] dma_page_fault_burst_len
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~((ADDR_WIDTH'(1) << LINE_OFFSET) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbClr,
    StRfReq,
    StRfClr,
    StDone,
    StErr
  } state_e;

  state_e                     state_q, state_d;
  logic [TimerW-1:0]          timer_q, timer_d;
  logic [ADDR_WIDTH-1:0]      wb_addr_q, wb_addr_d;
  logic [ADDR_WIDTH-1:0]      rf_addr_q, rf_addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic                       wb_happen_q, wb_happen_d;
  logic                       rf_happen_q, rf_happen_d;
  logic                       in_phase;
  logic                       timeout;

  always_comb begin
    state_d   = state_q;
    wb_addr_d = wb_addr_q;
    rf_addr_d = rf_addr_q;
    len_d     = len_q;
    in_phase  = (state_q == StWbReq) || (state_q == StWbClr) ||
                (state_q == StRfReq) || (state_q == StRfClr);
    timeout   = in_phase && (timer_q == TimerMax);

    unique case (state_q)
      StIdle: begin
        if (miss_valid) begin
          wb_addr_d = miss_victim_addr & AlignMask;
          rf_addr_d = miss_fill_addr & AlignMask;
          len_d     = miss_burst_len;
          if (miss_burst_len == '0) begin
            state_d = StDone;
          end else if (miss_dirty) begin
            state_d = StWbReq;
          end else begin
            state_d = StRfReq;
          end
        end
      end
      // Timeout wins over a done arriving in the same cycle.
      StWbReq: begin
        if (timeout) state_d = StErr;
        else if (dma_write_back_done) state_d = StWbClr;
      end
      StWbClr: begin
        if (timeout) state_d = StErr;
        else if (!dma_write_back_done) state_d = StRfReq;
      end
      StRfReq: begin
        if (timeout) state_d = StErr;
        else if (dma_page_fault_done) state_d = StRfClr;
      end
      StRfClr: begin
        if (timeout) state_d = StErr;
        else if (!dma_page_fault_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (in_phase && (timer_q != TimerMax)) begin
      timer_d = timer_q + TimerW'(1);
    end else begin
      timer_d = timer_q;
    end

    // Requests are decoded from the next state so they leave a flop glitch-free.
    wb_happen_d = (state_d == StWbReq);
    rf_happen_d = (state_d == StRfReq);
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      wb_addr_q   <= '0;
      rf_addr_q   <= '0;
      len_q       <= '0;
      wb_happen_q <= 1'b0;
      rf_happen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wb_addr_q   <= wb_addr_d;
      rf_addr_q   <= rf_addr_d;
      len_q       <= len_d;
      wb_happen_q <= wb_happen_d;
      rf_happen_q <= rf_happen_d;
    end
  end

  assign miss_ready               = (state_q == StIdle);
  assign miss_done                = (state_q == StDone);
  assign miss_error               = (state_q == StErr);
  assign dma_write_back_happen    = wb_happen_q;
  assign dma_page_fault_happen    = rf_happen_q;
  assign dma_write_back_addr      = wb_addr_q;
  assign dma_page_fault_addr      = rf_addr_q;
  assign dma_write_back_burst_len = len_q;
  assign dma_page_fault_burst_len = len_q;

endmodule
